// File: rtl/selout_pkg.sv
// Shared types and default constants for the selectable output block.
// Crossfade support is enabled by defining SELOUT_RAMP_EN at build time.
package selout_pkg;

  localparam int SELOUT_NCH       = 8;
  localparam int SELOUT_W         = 16;
  localparam int SELOUT_SELW      = 6;
  localparam int SELOUT_RAMP_LOG2 = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } selout_state_e;

endpackage

// File: rtl/selout_ramp.sv
// Combinational crossfade interpolator:
//   y = a + floor(((b - a) * (cnt + 1)) / 2**RAMP_LOG2)
// The difference is carried at W+1 bits and the product at W+1+RAMP_LOG2
// bits, so the result always lies between a and b and never wraps.
module selout_ramp
  import selout_pkg::*;
#(
  parameter int W         = SELOUT_W,
  parameter int RAMP_LOG2 = SELOUT_RAMP_LOG2
) (
  input  logic signed [W-1:0]         a,
  input  logic signed [W-1:0]         b,
  input  logic        [RAMP_LOG2-1:0] cnt,
  output logic signed [W-1:0]         y
);

  localparam int PW = W + 1 + RAMP_LOG2;

  logic signed [W:0]           diff;
  logic        [RAMP_LOG2:0]   step;
  logic signed [PW-1:0]        prod;

  // Difference, step weight and scaled product; the arithmetic shift floors.
  always_comb begin
    diff = {b[W-1], b} - {a[W-1], a};
    step = {1'b0, cnt} + (RAMP_LOG2 + 1)'(1);
    prod = PW'(diff) * $signed({{W{1'b0}}, step});
    y    = W'(PW'(a) + (prod >>> RAMP_LOG2));
  end

endmodule

// File: rtl/selectable_output_n.sv
// N-channel signed selector with an optional linear crossfade between the
// old and the new channel on every select change.
// Build option: SELOUT_RAMP_EN -- when defined, selection changes crossfade
// over 2**RAMP_LOG2 cycles; when undefined, selection switches at once.
// Select values >= NCH are ignored in both builds.
module selectable_output_n
  import selout_pkg::*;
#(
  parameter int NCH       = SELOUT_NCH,
  parameter int W         = SELOUT_W,
  parameter int SELW      = SELOUT_SELW,
  parameter int RAMP_LOG2 = SELOUT_RAMP_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*W-1:0]     in_bus,
  output logic signed [W-1:0]  out,
  output logic [SELW-1:0]      sel_act,
  output logic                 busy,
  output selout_state_e        state_dbg
);

  if (NCH < 2 || NCH > (1 << SELW) || RAMP_LOG2 < 1 || RAMP_LOG2 > 12) begin : g_bad_param
    $error("selectable_output_n: illegal NCH/SELW/RAMP_LOG2 combination");
  end

  logic                sel_valid;
  logic signed [W-1:0] act_val;

  assign sel_valid = (32'(sel) < NCH);

  // Value of the committed channel.
  always_comb begin
    act_val = '0;
    for (int k = 0; k < NCH; k++)
      if (sel_act == SELW'(k)) act_val = in_bus[k*W +: W];
  end

`ifdef SELOUT_RAMP_EN

  selout_state_e         state, state_nx;
  logic [RAMP_LOG2-1:0]  cnt;
  logic [SELW-1:0]       src, dst;
  logic signed [W-1:0]   src_val, dst_val, ramp_val;
  logic                  start, ramp_last;

  // Values of the crossfade source and destination channels.
  always_comb begin
    src_val = '0;
    dst_val = '0;
    for (int k = 0; k < NCH; k++) begin
      if (src == SELW'(k)) src_val = in_bus[k*W +: W];
      if (dst == SELW'(k)) dst_val = in_bus[k*W +: W];
    end
  end

  selout_ramp #(
    .W         (W),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_ramp (
    .a   (src_val),
    .b   (dst_val),
    .cnt (cnt),
    .y   (ramp_val)
  );

  // A new valid channel is only accepted while idle; changes during a
  // crossfade are looked at again on the first idle cycle.
  assign start     = (state == IDLE) && sel_valid && (sel != sel_act);
  assign ramp_last = (cnt == '1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = RAMP;
      RAMP:    if (ramp_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: output sample, committed channel and ramp bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      sel_act <= '0;
      cnt     <= '0;
      src     <= '0;
      dst     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out <= act_val;
          if (start) begin
            src <= sel_act;
            dst <= sel;
            cnt <= '0;
          end
        end
        RAMP: begin
          if (ramp_last) begin
            out     <= dst_val;
            sel_act <= dst;
          end else begin
            out <= ramp_val;
            cnt <= cnt + RAMP_LOG2'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy      = (state == RAMP);
    state_dbg = state;
  end

`else

  logic signed [W-1:0] sel_val;

  // Value of the requested channel.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SELW'(k)) sel_val = in_bus[k*W +: W];
  end

  // Immediate switch on a valid select; otherwise keep following sel_act.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      sel_act <= '0;
    end else if (sel_valid) begin
      out     <= sel_val;
      sel_act <= sel;
    end else begin
      out <= act_val;
    end
  end

  // No crossfade machine in this build.
  always_comb begin
    busy      = 1'b0;
    state_dbg = IDLE;
  end

`endif

endmodule

// File: tb/tb_selectable_output_n.sv
// Directed bench for selectable_output_n with NCH=8, W=16, SELW=6,
// RAMP_LOG2=2. Expected samples are hand-computed; the crossfade checks are
// compiled when SELOUT_RAMP_EN is defined, the direct-switch checks otherwise.
module tb_selectable_output_n;
  import selout_pkg::*;

  localparam int NCH       = 8;
  localparam int W         = 16;
  localparam int SELW      = 6;
  localparam int RAMP_LOG2 = 2;

  logic                clk;
  logic                rst;
  logic [SELW-1:0]     sel;
  logic [NCH*W-1:0]    in_bus;
  logic signed [W-1:0] out;
  logic [SELW-1:0]     sel_act;
  logic                busy;
  selout_state_e       state_dbg;

  logic signed [W-1:0] ch [NCH];
  logic signed [W-1:0] exp_q [$];

  int n_cmp;
  int n_err;

  selectable_output_n #(
    .NCH       (NCH),
    .W         (W),
    .SELW      (SELW),
    .RAMP_LOG2 (RAMP_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in_bus    (in_bus),
    .out       (out),
    .sel_act   (sel_act),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NCH; k++) in_bus[k*W +: W] = ch[k];
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int v);
    ch[k] = W'(v);
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(W'(v));
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // One complete crossfade: 2**RAMP_LOG2 + 1 edges, samples from exp_q.
  task automatic ramp_check(input string tag, input int from_ch, input int to_ch);
    logic signed [W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_out"}, $signed(out), e);
      end
      check({tag, "_busy"}, busy, (i < 4) ? 1 : 0);
      check({tag, "_state"}, state_dbg, (i < 4) ? 1 : 0);
      check({tag, "_sel_act"}, sel_act, (i < 4) ? from_ch : to_ch);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    sel   = '0;
    for (int k = 0; k < NCH; k++) ch[k] = '0;
    set_ch(0, 1000);

    // Reset state
    tick();
    tick();
    check("rst_out", $signed(out), 0);
    check("rst_busy", busy, 0);
    check("rst_sel_act", sel_act, 0);

    // First edge after release follows the idle rules
    rst = 1'b0;
    tick();
    check("rel_out", $signed(out), 1000);
    check("rel_busy", busy, 0);

`ifdef SELOUT_RAMP_EN
    // Basic crossfade 0 -> 1
    set_ch(0, 0);
    set_ch(1, 400);
    sel = 1;
    push_exp(0); push_exp(100); push_exp(200); push_exp(300); push_exp(400);
    ramp_check("ramp01", 0, 1);
    tick();
    check("hold1_out", $signed(out), 400);

    // Crossfade 1 -> 3 with uneven step
    set_ch(3, 777);
    sel = 3;
    push_exp(400); push_exp(494); push_exp(588); push_exp(682); push_exp(777);
    ramp_check("ramp13", 1, 3);

    // Out-of-range select is ignored
    sel = 9;
    tick();
    check("inval_out", $signed(out), 777);
    check("inval_busy", busy, 0);
    check("inval_sel_act", sel_act, 3);
    set_ch(3, -50);
    tick();
    check("inval_track_out", $signed(out), -50);
    check("inval_track_sel_act", sel_act, 3);
    check("inval_track_busy", busy, 0);

    // Return to channel 0 parked at the negative extreme
    set_ch(0, -32768);
    set_ch(3, -32768);
    sel = 0;
    repeat (5) push_exp(-32768);
    ramp_check("ramp30", 3, 0);

    // Full-scale crossfade up and back down
    set_ch(1, 32767);
    sel = 1;
    push_exp(-32768); push_exp(-16385); push_exp(-1); push_exp(16383); push_exp(32767);
    ramp_check("ext_up", 0, 1);
    sel = 0;
    push_exp(32767); push_exp(16383); push_exp(-1); push_exp(-16385); push_exp(-32768);
    ramp_check("ext_dn", 1, 0);

    // Select toggling mid-ramp is ignored, then re-evaluated when idle
    set_ch(0, 0);
    set_ch(1, 400);
    set_ch(2, 800);
    sel = 1;
    tick();
    check("dist_c0_out", $signed(out), 0);
    check("dist_c0_busy", busy, 1);
    sel = 2;
    tick();
    check("dist_c1_out", $signed(out), 100);
    sel = 0;
    tick();
    check("dist_c2_out", $signed(out), 200);
    tick();
    check("dist_c3_out", $signed(out), 300);
    check("dist_c3_sel_act", sel_act, 0);
    tick();
    check("dist_end_out", $signed(out), 400);
    check("dist_end_busy", busy, 0);
    check("dist_end_sel_act", sel_act, 1);
    tick();
    check("dist_back_out", $signed(out), 400);
    check("dist_back_busy", busy, 1);
    check("dist_back_sel_act", sel_act, 1);
    tick();
    check("dist_back1_out", $signed(out), 300);

    // Reset aborts the crossfade
    rst = 1'b1;
    set_ch(0, 123);
    tick();
    check("abort_out", $signed(out), 0);
    check("abort_busy", busy, 0);
    check("abort_sel_act", sel_act, 0);
    rst = 1'b0;
    tick();
    check("abort_rel_out", $signed(out), 123);
    check("abort_rel_busy", busy, 0);
    check("abort_rel_sel_act", sel_act, 0);
`else
    // Direct switch 0 -> 5
    set_ch(5, 555);
    sel = 5;
    tick();
    check("sw5_out", $signed(out), 555);
    check("sw5_sel_act", sel_act, 5);
    check("sw5_busy", busy, 0);
    set_ch(5, -7);
    tick();
    check("sw5_track_out", $signed(out), -7);
    check("sw5_track_busy", busy, 0);

    // Out-of-range select keeps following the committed channel
    sel = 9;
    set_ch(5, 42);
    tick();
    check("inval_out", $signed(out), 42);
    check("inval_sel_act", sel_act, 5);
    check("inval_busy", busy, 0);

    // Back to channel 0, then extremes
    sel = 0;
    tick();
    check("sw0_out", $signed(out), 1000);
    check("sw0_sel_act", sel_act, 0);
    set_ch(1, 32767);
    sel = 1;
    tick();
    check("ext_hi_out", $signed(out), 32767);
    set_ch(0, -32768);
    sel = 0;
    tick();
    check("ext_lo_out", $signed(out), -32768);
    check("ext_lo_busy", busy, 0);

    // Reset clears everything
    rst = 1'b1;
    sel = 1;
    tick();
    check("rst2_out", $signed(out), 0);
    check("rst2_sel_act", sel_act, 0);
    check("rst2_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rst2_rel_out", $signed(out), 32767);
    check("rst2_rel_sel_act", sel_act, 1);
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/selectable_output_n.md
SELECTABLE_OUTPUT_N -- requirements
Module: selectable_output_n

Interface
REQ-001 Parameter NCH, default 8: number of input channels; SHALL satisfy 2 <= NCH <= 2**SELW.
REQ-002 Parameter W, default 16: signed sample width of every input and the output.
REQ-003 Parameter SELW, default 6: select width.
REQ-004 Parameter RAMP_LOG2, default 8: crossfade length is 2**RAMP_LOG2 cycles; legal range 1..12.
REQ-005 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sel  in  SELW  requested channel: 0 selects channel 0, 1 selects channel 1, and so on.
REQ-008 in_bus  in  NCH*W  signed channels; channel k occupies bits [k*W +: W].
REQ-009 out  out  W  signed registered output.
REQ-010 sel_act  out  SELW  channel currently committed to the output.
REQ-011 busy  out  1  high while a crossfade is in progress.

Function
REQ-012 A sel value >= NCH SHALL be ignored: sel_act, state and the output source are unchanged.
REQ-013 State machine SHALL have two states, IDLE and RAMP.
REQ-014 In IDLE with sel valid and sel == sel_act, out SHALL be assigned in[sel_act] each cycle, with 1-cycle latency from in_bus.
REQ-015 In IDLE with sel valid and sel != sel_act, the following SHALL occur at that edge:
- src latched to sel_act, dst latched to sel.
- cnt cleared to 0.
- state set to RAMP.
- out assigned in[src].
REQ-016 In RAMP with cnt = c < 2**RAMP_LOG2-1, the following SHALL occur at each edge:
- out assigned in[src] + floor(((in[dst]-in[src]) * (c+1)) / 2**RAMP_LOG2), using live input values.
- cnt incremented.
REQ-017 In RAMP with cnt = 2**RAMP_LOG2-1, the following SHALL occur at that edge:
- out assigned in[dst].
- sel_act set to dst.
- state set to IDLE.
REQ-018 Arithmetic widths:
- Difference computed at W+1 bits.
- Product computed at W+1+RAMP_LOG2 bits.
- Shift is an arithmetic right shift.
- The result SHALL lie between in[src] and in[dst] inclusive, with no overflow or wrap.
REQ-019 sel changes during RAMP, including a return to src, SHALL be ignored until RAMP completes; the first IDLE cycle then evaluates sel per REQ-014/015.
REQ-020 busy SHALL be 1 exactly while state == RAMP; sel_act SHALL change only on RAMP completion.

Reset
REQ-021 On rst high at a clock edge:
- out = 0, sel_act = 0, busy = 0.
- state = IDLE, cnt = 0.
- src = 0, dst = 0.
REQ-022 rst high during RAMP SHALL abort the crossfade immediately, with no completion of pending dst.
REQ-023 The first edge after rst is released SHALL follow the normal IDLE rules.

Configuration
REQ-024 Macro SELOUT_RAMP_EN defined: the crossfade behaviour of REQ-015..020 is compiled in.
REQ-025 Macro SELOUT_RAMP_EN undefined:
- No RAMP state and no multiplier is built.
- A valid sel SHALL update sel_act and drive out <= in[sel] at the same edge (1-cycle latency).
- An invalid sel SHALL drive out <= in[sel_act].
- busy SHALL be tied to 0.

Structure
REQ-026 Shared package selout_pkg SHALL hold:
- The state enum {IDLE, RAMP}.
- Default constants for W, SELW, NCH and RAMP_LOG2.
REQ-027 The interpolation arithmetic SHALL be a sub-module, selout_ramp:
- Inputs: a, b, cnt.
- Output: combinational interpolated value.
- Instantiated only under SELOUT_RAMP_EN.

Verification
REQ-028 Reset, then sel=0 with in0=1000 -> out=0 during reset; out=1000 one cycle after release; busy=0.
REQ-029 RAMP_LOG2=2, in0=0, in1=400, sel 0->1 -> out sequence 0,100,200,300,400; busy high for 4 cycles; sel_act=1 at the 400 edge.
REQ-030 NCH=8, sel=9 while sel_act=3 -> no ramp started; out tracks in3; sel_act stays 3.
REQ-031 Extremes, W=16: in0=-32768, in1=32767, full ramp both directions -> out monotonic with no wrap; ends exactly at 32767 going up and -32768 going down.
REQ-032 Disturbances mid-ramp:
- sel toggled 1->2->0 during a 0->1 ramp -> ramp completes to 1, then a ramp 1->0 starts on the next cycle.
- rst asserted mid-ramp -> out=0, busy=0, sel_act=0 on the next edge.
REQ-033 Build without SELOUT_RAMP_EN, sel 0->5 -> out equals in5 one cycle later; busy stays 0 throughout.
